locked_reg_reader: RTL



---
 rtl/locked_reg_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/locked_reg_reader.sv
// Secure readback port for a bank of lockable configuration registers.
// Each read is checked against the target register's lock state; repeated denials set a sticky alarm.
`timescale 1ns/1ps
module locked_reg_reader #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned MAX_DENY = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                         Clk,
  input  logic                         resetn,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_busy,
  output logic                         rsp_valid,
  input  logic                         rsp_ack,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_err,
  input  logic [NUM_REGS*DATA_W-1:0]   Reg_in,
  input  logic [NUM_REGS-1:0]          lock_status,
  input  logic                         scan_mode,
  input  logic                         debug_unlocked,
  output logic                         alarm,
  output logic [CNT_W-1:0]             deny_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DENY);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic                alarm_q, alarm_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DATA_W-1:0]   sel_data;
  logic                sel_lock;
  logic                addr_ok;
  logic                grant;

  // Mux the addressed register and its lock bit out of the flattened bank.
  always_comb begin
    sel_data = '0;
    sel_lock = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        sel_data = Reg_in[i*DATA_W +: DATA_W];
        sel_lock = lock_status[i];
      end
    end
  end

  // Debug unlock is only honoured outside scan; an alarm blocks everything.
  assign addr_ok = 32'(addr_q) < NUM_REGS;
  assign grant   = addr_ok & ~alarm_q & (~sel_lock | (debug_unlocked & ~scan_mode));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = valid_q;
    alarm_d = alarm_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          addr_d  = rd_addr;
          state_d = CHECK;
        end
      end
      CHECK: begin
        valid_d = 1'b1;
        state_d = RESP;
        if (grant) begin
          data_d = sel_data;
          err_d  = 1'b0;
        end else begin
          data_d = '0;
          err_d  = 1'b1;
          // Saturate at the threshold; alarm rises on the edge the threshold is reached.
          if (cnt_q < MAX_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == MAX_CNT) alarm_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      alarm_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      alarm_q <= alarm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd_busy    = (state_q != IDLE);
  assign rsp_valid  = valid_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign alarm      = alarm_q;
  assign deny_count = cnt_q;

endmodule
